ram_loader: RTL

- Upstream stage of the ByteBlast RAM.
- Accepts a framed byte stream over a valid/ready handshake, usually from the serial receiver.
- Writes the payload into consecutive RAM addresses starting at 0 by driving the RAM's enable, address and data_in ports.
- Reports busy/done/error so the controller knows when the RAM image is ready for execution.

---
 rtl/ram_loader_pkg.sv | 17 +
 rtl/ram_loader_if.sv | 32 +++
 rtl/ram_loader_wr_stage.sv | 43 ++++
 rtl/ram_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and default widths for the ByteBlast RAM loader.
// Holds the loader state encoding and the address/data widths shared with the RAM.
// No logic; imported by the interface, the write stage and the top.
package ram_loader_pkg;

    localparam int DEF_ADDRESS_BITS = 6;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream in (valid/ready) plus RAM write port out, bundled for the loader.
// Ports: in_data/in_valid/in_ready stream; ram_enable/ram_address/ram_data_in write port.
// Modports: loader (the ram_loader), source (stream producer), ram (RAM write side).
interface ram_loader_if
    import ram_loader_pkg::*;
#(
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS
);

    logic [DATA_BITS-1:0]    in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    ram_enable;
    logic [ADDRESS_BITS-1:0] ram_address;
    logic [DATA_BITS-1:0]    ram_data_in;

    modport loader (
        input  in_data, in_valid,
        output in_ready, ram_enable, ram_address, ram_data_in
    );

    modport source (
        output in_data, in_valid,
        input  in_ready
    );

    modport ram (
        input  ram_enable, ram_address, ram_data_in
    );

endinterface

// File: rtl/ram_loader_wr_stage.sv
// Registered RAM write stage: one accepted payload byte becomes one ram_enable pulse.
// Latency 1 cycle from the transfer edge; address/data hold when no write is pending.
// No backpressure: the RAM always takes a write. Ports: clk, rst, wr_vld_i/wr_addr_i/wr_dat_i in, ram_*_o out.
module ram_loader_wr_stage
    import ram_loader_pkg::*;
#(
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_vld_i,
    input  logic [ADDRESS_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0]    wr_dat_i,
    output logic                    ram_enable_o,
    output logic [ADDRESS_BITS-1:0] ram_address_o,
    output logic [DATA_BITS-1:0]    ram_data_o
);

    logic                    en_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0]    dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
        end else begin
            en_q <= wr_vld_i;
            // Address/data only move on a real write so the RAM bus stays quiet between bytes.
            if (wr_vld_i) begin
                addr_q <= wr_addr_i;
                dat_q  <= wr_dat_i;
            end
        end
    end

    assign ram_enable_o  = en_q;
    assign ram_address_o = addr_q;
    assign ram_data_o    = dat_q;

endmodule

// File: rtl/ram_loader.sv
// Frame loader: header byte (length-1), payload bytes written to RAM from address 0.
// Latency: each payload byte appears on the RAM port one cycle after its transfer edge.
// Backpressure: in_ready is a pure state decode (LEN/DATA/CSUM); the source may stall freely.
// Ports: clk, rst (sync, active-high), start pulse, bus (stream + RAM write port),
//        busy/done/error status, byte_count of payload bytes written.
// Optional macro RAM_LOADER_CHECKSUM_EN adds a trailing modular-sum checksum byte.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ram_loader_if.loader          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDRESS_BITS:0] byte_count
);

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] last_addr_q, last_addr_d;
    logic [ADDRESS_BITS:0]   count_q, count_d;
    logic                    error_q, error_d;
    logic                    in_ready_w;
    logic                    xfer;
    logic                    hdr_bad;
    logic                    wr_vld;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [DATA_BITS-1:0]    sum_q, sum_d;
    logic [DATA_BITS-1:0]    csum_w;
`endif

    assign in_ready_w = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign xfer       = bus.in_valid && in_ready_w;
    // Shift rather than slice so DATA_BITS == ADDRESS_BITS (no spare header bits) stays legal.
    assign hdr_bad    = (bus.in_data >> ADDRESS_BITS) != '0;
`ifdef RAM_LOADER_CHECKSUM_EN
    assign csum_w     = sum_q + bus.in_data;
`endif

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        count_d     = count_q;
        error_d     = error_q;
        wr_vld      = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LEN;
                    count_d = '0;
                    error_d = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (hdr_bad) begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end else begin
                        last_addr_d = bus.in_data[ADDRESS_BITS-1:0];
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    wr_vld  = 1'b1;
                    count_d = count_q + 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + bus.in_data;
`endif
                    // Compare on the address bits so a full 2^N load ends without wrapping.
                    if (count_q[ADDRESS_BITS-1:0] == last_addr_q) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    if (csum_w == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_addr_q <= '0;
            count_q     <= '0;
            error_q     <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            count_q     <= count_d;
            error_q     <= error_d;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    ram_loader_wr_stage #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .DATA_BITS    (DATA_BITS)
    ) u_wr_stage (
        .clk           (clk),
        .rst           (rst),
        .wr_vld_i      (wr_vld),
        .wr_addr_i     (count_q[ADDRESS_BITS-1:0]),
        .wr_dat_i      (bus.in_data),
        .ram_enable_o  (bus.ram_enable),
        .ram_address_o (bus.ram_address),
        .ram_data_o    (bus.ram_data_in)
    );

    assign bus.in_ready = in_ready_w;
    assign busy         = in_ready_w;
    assign done         = (state_q == ST_DONE);
    assign error        = error_q;
    assign byte_count   = count_q;

endmodule
